// File: rtl/seg_capture.sv
// Sense-side decoder for a two-digit multiplexed seven-segment display.
// Synchronizes the pins and commits each digit after STABLE_CNT identical samples.

module seg_track #(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  input  logic       illegal,
  input  logic [4:0] code,
  output logic [3:0] digit,
  output logic       valid,
  output logic       chg
);
  localparam logic [4:0] BLANK = 5'h10;
  localparam logic [3:0] STB   = 4'(STABLE_CNT);

  logic [4:0] cand;
  logic [3:0] cnt, cnt_nxt;
  logic       match, commit;

  always_comb begin
    match   = (code == cand);
    cnt_nxt = match ? ((cnt == STB) ? cnt : cnt + 4'd1) : 4'd1;
    // A saturated match is a hold, not a fresh arrival at STABLE_CNT.
    commit  = hit && !illegal && (cnt_nxt == STB) && !(match && (cnt == STB));
    chg     = commit && (code[4] ? valid : (!valid || (digit != code[3:0])));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cand  <= BLANK;
      cnt   <= 4'd0;
      digit <= 4'd0;
      valid <= 1'b0;
    end else if (hit) begin
      if (illegal) begin
        cand <= BLANK;
        cnt  <= 4'd0;
      end else begin
        cand <= code;
        cnt  <= cnt_nxt;
        if (commit) begin
          if (code[4]) valid <= 1'b0;
          else begin
            digit <= code[3:0];
            valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

module seg_capture #(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_sel,
  input  logic       clr_err,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [1:0] valid,
  output logic       upd,
  output logic       err
);
  logic [6:0] seg_m, seg_s;
  logic [1:0] sel_m, sel_s;
  logic [4:0] code;
  logic       illegal, err_ev;
  logic [1:0] hit, chg;
  logic [1:0][3:0] dig_arr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_m <= 7'h7f;
      seg_s <= 7'h7f;
      sel_m <= 2'b00;
      sel_s <= 2'b00;
    end else begin
      seg_m <= seg_in;
      seg_s <= seg_m;
      sel_m <= dig_sel;
      sel_s <= sel_m;
    end
  end

  // code[4] set means BLANK; illegal patterns flagged separately.
  always_comb begin
    illegal = 1'b0;
    code    = 5'h10;
    case (seg_s)
      7'b1000000: code = 5'h00;
      7'b1111001: code = 5'h01;
      7'b0100100: code = 5'h02;
      7'b0110000: code = 5'h03;
      7'b0011001: code = 5'h04;
      7'b0010010: code = 5'h05;
      7'b0000010: code = 5'h06;
      7'b1111000: code = 5'h07;
      7'b0000000: code = 5'h08;
      7'b0010000: code = 5'h09;
      7'b0001000: code = 5'h0a;
      7'b0000011: code = 5'h0b;
      7'b1000110: code = 5'h0c;
      7'b0100001: code = 5'h0d;
      7'b0000110: code = 5'h0e;
      7'b0001110: code = 5'h0f;
      7'b1111111: code = 5'h10;
      default:    illegal = 1'b1;
    endcase
  end

  assign hit    = {2{sample_en}} & {sel_s == 2'b10, sel_s == 2'b01};
  assign err_ev = (sample_en && (sel_s == 2'b11)) || ((|hit) && illegal);

  for (genvar g = 0; g < 2; g++) begin : g_trk
    seg_track #(.STABLE_CNT(STABLE_CNT)) u_trk (
      .clk    (clk),
      .reset  (reset),
      .hit    (hit[g]),
      .illegal(illegal),
      .code   (code),
      .digit  (dig_arr[g]),
      .valid  (valid[g]),
      .chg    (chg[g])
    );
  end

  assign digit0 = dig_arr[0];
  assign digit1 = dig_arr[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      upd <= 1'b0;
      err <= 1'b0;
    end else begin
      upd <= |chg;
      if (err_ev)       err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end
endmodule

// File: doc/seg_capture.md
# seg_capture

Sense-side companion to the time-multiplexed two-digit seven-segment driver. The block watches the segment and digit-select lines, synchronizes them, and decodes each active-low segment pattern back to a hex nibble. It commits a digit only after a configurable number of consecutive identical samples. Board-level self-check logic and the lab readback path use it to confirm what the display is actually showing.

## Interface
- STABLE_CNT, 4: consecutive identical qualified samples needed to commit a digit (legal 1..15)
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- sample_en  in  1  one-cycle strobe; qualifies the synchronized inputs for sampling in that cycle
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}, active-low (0 = lit), asynchronous to clk
- dig_sel  in  2  digit enables, active-high one-hot; bit0 = digit 0 (right), bit1 = digit 1 (left); asynchronous
- clr_err  in  1  clears err (synchronous, level)
- digit0  out  4  last committed value of digit 0
- digit1  out  4  last committed value of digit 1
- valid  out  2  valid[n] = 1 when digitn holds a committed, non-blank value
- upd  out  1  one-cycle pulse when digit0/digit1/valid changes
- err  out  1  sticky: illegal pattern or illegal dig_sel sampled

## Operation
- seg_in and dig_sel pass through a 2-flop synchronizer. All decisions use the synchronized copies (seg_s, sel_s).
- Decode table (seg_s -> nibble): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F. 1111111 = BLANK. All other patterns = ILLEGAL.
- A cycle is a qualified sample when sample_en=1. Cycles with sample_en=0 change nothing.
- sel_s=01 or 10 selects digit n. The sample updates only that digit's tracker: cand[n] (5-bit code: nibble or BLANK) and cnt[n] (4-bit).
- Tracker, per sample:
  - decoded code == cand[n]: cnt[n] increments, saturating at STABLE_CNT.
  - code differs: cand[n] <= code and cnt[n] <= 1.
- Commit: when cnt[n] transitions to STABLE_CNT, cand[n] is committed.
  - Nibble: digitn <= nibble, valid[n] <= 1.
  - BLANK: valid[n] <= 0 and digitn holds its old value.
  - upd pulses only if digitn or valid[n] actually changes.
  - STABLE_CNT=1 commits on the first sample of a new code.
- ILLEGAL pattern: err <= 1, cand[n] <= BLANK, cnt[n] <= 0. Committed outputs are unchanged.
- sel_s=00: the sample is ignored (inter-digit dead time).
- sel_s=11: the sample is ignored and err <= 1.
- clr_err=1 clears err. If an error event occurs in the same cycle, set wins.
- Digits are independent. Interleaved samples of digit 0 and digit 1 do not disturb each other's counts.

## Timing
- Reset (reset=0 at a clk edge) sets:
  - digit0=digit1=0, valid=00, upd=0, err=0
  - cand[0..1]=BLANK, cnt=0
  - synchronizer flops = 1111111 / 00
- Reset mid-accumulation discards partial counts. No commit occurs on the reset cycle.
- Pin-to-seg_s latency is 2 clk.
- The commit is registered. digitn, valid[n] and upd change on the clk edge after the STABLE_CNT-th matching qualified sample. upd is high for exactly that one cycle.
- Minimum pin-to-output latency is 2 + STABLE_CNT cycles, with sample_en held high and pins steady.
- Back-to-back commits on alternating digits are allowed in consecutive cycles. Each produces its own upd pulse.

## Test plan
- Pattern 0100100, dig_sel=01, sample_en=1 continuously, STABLE_CNT=4 -> digit0=2, valid=01 and upd pulse 6 cycles after the pins change; no further upd while the pins are held.
- Alternate dig_sel 01/10 each cycle with 0000011 / 1111000 -> digit0=b, digit1=7, valid=11; two separate upd pulses; err=0.
- Digit 1 with 0110000 for 3 samples, then 0010010 for 4 samples -> no commit of 3; digit1=5 commits after the 4th sample of 5.
- Digit 0 committed as 8, then 1111111 for 4 samples -> valid[0]=0, digit0 stays 8, one upd pulse.
- Pattern 1010101 on digit 0, then dig_sel=11 -> err=1 on the first event, digit0/valid unchanged; clr_err=1 with no new event -> err=0.
- reset=0 asserted after 2 of 4 matching samples of 9 -> all outputs 0 on the next edge; after release, 4 fresh samples are required before digit0=9.
